// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: turns the PC register's fetch requests into
// SRAM-like instruction transactions (one outstanding at most) and presents a
// registered fetch result to IF/ID, with a one-entry skid buffer for stalls
// and discard tracking for transactions overtaken by an exception flush.
module if_fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              pc_read_ready_o,
    output logic              addr_ok_o,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [DATA_W-1:0] inst_rdata_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [DATA_W-1:0] if_inst_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic              discard;
    logic              discard_nxt;

    // control strobes produced by the next-state logic
    logic              latch_pc;
    logic              load_mem;
    logic              load_skid;
    logic              skid_to_out;
    logic              accept;

    // registered fetch result (the IF/ID-facing stage)
    logic              vld_p1;
    logic [ADDR_W-1:0] pc_p1;
    logic [DATA_W-1:0] inst_p1;

    // one-entry skid buffer used when data returns into a full, stalled stage
    logic              skid_vld;
    logic [ADDR_W-1:0] skid_pc;
    logic [DATA_W-1:0] skid_inst;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and strobe decode; flush always wins over normal progress
    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        latch_pc    = 1'b0;
        load_mem    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                // a flush restarts fetching at the vector even if ce_i is low
                if (flush_i || ce_i) begin
                    state_nxt = ADDR;
                    latch_pc  = 1'b1;
                end
            end
            ADDR: begin
                // the request cannot be withdrawn, so a flush only marks it stale
                if (flush_i) begin
                    discard_nxt = 1'b1;
                end
                if (inst_addr_ok_i) begin
                    state_nxt = DATA;
                    accept    = !discard && !flush_i;
                end
            end
            DATA: begin
                if (inst_data_ok_i) begin
                    if (discard || flush_i) begin
                        // stale word: drop it and fetch from the new PC
                        discard_nxt = 1'b0;
                        state_nxt   = ADDR;
                        latch_pc    = 1'b1;
                    end else if (vld_p1 && stall_i) begin
                        load_skid = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        load_mem = 1'b1;
                        if (ce_i) begin
                            state_nxt = ADDR;
                            latch_pc  = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end else if (flush_i) begin
                    discard_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_nxt = ADDR;
                    latch_pc  = 1'b1;
                end else if (!stall_i) begin
                    skid_to_out = skid_vld;
                    if (ce_i) begin
                        state_nxt = ADDR;
                        latch_pc  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request address and discard flag; the address holds until the next fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_addr <= '0;
            discard  <= 1'b0;
        end else begin
            discard <= discard_nxt;
            if (latch_pc) begin
                req_addr <= pc_i;
            end
        end
    end

    // Output stage: flush clears, a reload beats a same-cycle consume
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            pc_p1   <= '0;
            inst_p1 <= '0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (load_mem) begin
            vld_p1  <= 1'b1;
            pc_p1   <= req_addr;
            inst_p1 <= inst_rdata_i;
        end else if (skid_to_out) begin
            vld_p1  <= 1'b1;
            pc_p1   <= skid_pc;
            inst_p1 <= skid_inst;
        end else if (vld_p1 && !stall_i) begin
            vld_p1 <= 1'b0;
        end
    end

    // Skid valid flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_vld <= 1'b0;
        end else if (flush_i) begin
            skid_vld <= 1'b0;
        end else if (load_skid) begin
            skid_vld <= 1'b1;
        end else if (skid_to_out) begin
            skid_vld <= 1'b0;
        end
    end

    // Skid payload; only meaningful while skid_vld is set
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_pc   <= req_addr;
            skid_inst <= inst_rdata_i;
        end
    end

    assign pc_read_ready_o = accept;
    assign addr_ok_o       = accept;
    assign inst_req_o      = (state == ADDR);
    assign inst_addr_o     = req_addr;
    assign if_valid_o      = vld_p1;
    assign if_pc_o         = pc_p1;
    assign if_inst_o       = inst_p1;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a bench-side SRAM-like memory responder, a PC
// register model that advances on pc_read_ready_o, and a scoreboard of
// expected fetch results filled when the memory returns data and drained when
// IF/ID consumes the output register.
module tb_if_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_i = '0;
    logic        ce_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        pc_read_ready_o;
    logic        addr_ok_o;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i = 1'b0;
    logic        inst_data_ok_i = 1'b0;
    logic [31:0] inst_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    int          n_vec = 0;
    int          n_err = 0;
    fetch_t      sb_q[$];
    int          rr_cnt = 0;

    // memory responder configuration and state
    int          addr_wait = 0;
    int          data_wait = 1;
    int          awcnt = 0;
    int          dcnt = 0;
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;

    // requests from the main sequence to the monitor process
    int          drops_req = 0;
    int          drops_done = 0;
    int          pc_req_seq = 0;
    int          pc_seen_seq = 0;
    logic [31:0] pc_req_val = '0;

    if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .ce_i            (ce_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .pc_read_ready_o (pc_read_ready_o),
        .addr_ok_o       (addr_ok_o),
        .inst_req_o      (inst_req_o),
        .inst_addr_o     (inst_addr_o),
        .inst_addr_ok_i  (inst_addr_ok_i),
        .inst_data_ok_i  (inst_data_ok_i),
        .inst_rdata_i    (inst_rdata_i),
        .if_valid_o      (if_valid_o),
        .if_pc_o         (if_pc_o),
        .if_inst_o       (if_inst_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'hBFC00000: return 32'h3C010001;
            32'hBFC00004: return 32'h24210004;
            default:      return a ^ 32'h5A5A0000;
        endcase
    endfunction

    // memory: addr_ok after addr_wait cycles of request, data_ok data_wait cycles later
    always begin
        @(posedge clk);
        #1;
        inst_addr_ok_i = 1'b0;
        inst_data_ok_i = 1'b0;
        if (pend) begin
            if (dcnt <= 1) begin
                inst_data_ok_i = 1'b1;
                inst_rdata_i   = mem_word(paddr);
                pend           = 1'b0;
            end else begin
                dcnt--;
            end
        end
        if (inst_req_o) begin
            if (awcnt < addr_wait) begin
                awcnt++;
            end else begin
                inst_addr_ok_i = 1'b1;
                awcnt          = 0;
                pend           = 1'b1;
                dcnt           = data_wait;
                paddr          = inst_addr_o;
            end
        end
    end

    // monitor: scoreboard pop/push, PC register model
    always @(negedge clk) begin
        fetch_t e;
        if (!rst) begin
            sb_q.delete();
        end else begin
            if (if_valid_o && !stall_i) begin
                if (sb_q.size() == 0) begin
                    chk("spurious if_valid_o", if_valid_o, 1'b0);
                end else begin
                    e = sb_q.pop_front();
                    chk("out pc", if_pc_o, e.pc);
                    chk("out inst", if_inst_o, e.inst);
                end
            end
            if (pc_read_ready_o) begin
                rr_cnt++;
                pc_i = pc_i + 32'd4;
            end
            if (inst_data_ok_i) begin
                if (drops_done < drops_req) begin
                    drops_done++;
                end else begin
                    sb_q.push_back('{paddr, mem_word(paddr)});
                end
            end
        end
        if (pc_req_seq != pc_seen_seq) begin
            pc_i        = pc_req_val;
            pc_seen_seq = pc_req_seq;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_req_val = v;
        pc_req_seq++;
    endtask

    initial begin
        #2 rst = 1'b0;
        look();
        look();
        chk("rst inst_req_o", inst_req_o, 1'b0);
        chk("rst inst_addr_o", inst_addr_o, 32'h0);
        chk("rst pc_read_ready_o", pc_read_ready_o, 1'b0);
        chk("rst addr_ok_o", addr_ok_o, 1'b0);
        chk("rst if_valid_o", if_valid_o, 1'b0);
        chk("rst if_pc_o", if_pc_o, 32'h0);
        chk("rst if_inst_o", if_inst_o, 32'h0);

        // basic fetch
        tick(); rst = 1'b1; ce_i = 1'b1; load_pc(32'hBFC00000);
        look(); chk("basic idle req", inst_req_o, 1'b0);
        tick(); look();
        chk("basic req", inst_req_o, 1'b1);
        chk("basic addr", inst_addr_o, 32'hBFC00000);
        chk("basic ready", pc_read_ready_o, 1'b1);
        chk("basic addr_ok_o", addr_ok_o, 1'b1);
        tick(); ce_i = 1'b0;
        look(); chk("basic latency", if_valid_o, 1'b0);
        tick(); look();
        chk("basic valid", if_valid_o, 1'b1);
        chk("basic pc", if_pc_o, 32'hBFC00000);
        chk("basic inst", if_inst_o, 32'h3C010001);
        chk("basic ready count", rr_cnt, 1);
        tick(); look(); chk("basic consumed", if_valid_o, 1'b0);

        // stall backpressure into the skid buffer
        tick(); ce_i = 1'b1; stall_i = 1'b1; load_pc(32'hBFC00000);
        tick(); tick(); tick();
        look(); chk("stall first held", if_valid_o, 1'b1);
        tick(); ce_i = 1'b0;
        tick(); look();
        chk("hold valid", if_valid_o, 1'b1);
        chk("hold pc", if_pc_o, 32'hBFC00000);
        chk("hold inst", if_inst_o, 32'h3C010001);
        chk("hold no req", inst_req_o, 1'b0);
        tick(); stall_i = 1'b0;
        look(); chk("release pc", if_pc_o, 32'hBFC00000);
        tick(); look();
        chk("skid valid", if_valid_o, 1'b1);
        chk("skid pc", if_pc_o, 32'hBFC00004);
        chk("skid inst", if_inst_o, 32'h24210004);
        tick(); look();
        chk("stall drained", if_valid_o, 1'b0);
        chk("stall ready count", rr_cnt, 3);
        chk("stall sb empty", sb_q.size(), 0);

        // flush while waiting in DATA
        data_wait = 3;
        tick(); ce_i = 1'b1;
        tick(); look(); chk("fdata accept", pc_read_ready_o, 1'b1);
        tick(); flush_i = 1'b1; drops_req++; load_pc(32'hBFC00380);
        look(); chk("fdata no ready", pc_read_ready_o, 1'b0);
        tick(); flush_i = 1'b0;
        look(); chk("fdata no valid", if_valid_o, 1'b0);
        tick(); look(); chk("fdata stale dropped", if_valid_o, 1'b0);
        tick(); ce_i = 1'b0;
        look();
        chk("fdata req", inst_req_o, 1'b1);
        chk("fdata vector", inst_addr_o, 32'hBFC00380);
        data_wait = 1;
        tick(); tick(); tick(); tick(); look();
        chk("fdata valid", if_valid_o, 1'b1);
        chk("fdata pc", if_pc_o, 32'hBFC00380);
        tick(); look();
        chk("fdata ready count", rr_cnt, 5);
        chk("fdata sb empty", sb_q.size(), 0);

        // flush coincident with addr_ok
        tick(); ce_i = 1'b1;
        tick(); flush_i = 1'b1; drops_req++; load_pc(32'hBFC00380);
        look();
        chk("faddr req", inst_req_o, 1'b1);
        chk("faddr no ready", pc_read_ready_o, 1'b0);
        tick(); flush_i = 1'b0; ce_i = 1'b0;
        look(); chk("faddr stale dropped", if_valid_o, 1'b0);
        tick(); look();
        chk("faddr req again", inst_req_o, 1'b1);
        chk("faddr vector", inst_addr_o, 32'hBFC00380);
        tick(); tick(); look();
        chk("faddr valid", if_valid_o, 1'b1);
        chk("faddr pc", if_pc_o, 32'hBFC00380);
        tick(); look();
        chk("faddr ready count", rr_cnt, 6);
        chk("faddr sb empty", sb_q.size(), 0);

        // wait-state memory: addr_ok after three idle request cycles
        addr_wait = 3;
        tick(); ce_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 2) ce_i = 1'b0;
            look();
            chk("ws req", inst_req_o, 1'b1);
            chk("ws addr", inst_addr_o, 32'hBFC00384);
            chk("ws ready", pc_read_ready_o, (k == 4));
        end
        addr_wait = 0;
        tick(); tick(); look();
        chk("ws valid", if_valid_o, 1'b1);
        chk("ws pc", if_pc_o, 32'hBFC00384);
        tick(); look();
        chk("ws ready count", rr_cnt, 7);
        chk("ws sb empty", sb_q.size(), 0);

        // asynchronous reset in the middle of DATA
        tick(); ce_i = 1'b1; stall_i = 1'b1;
        tick(); look(); data_wait = 3;
        tick();
        tick(); ce_i = 1'b0; drops_req++;
        tick(); look();
        chk("pre-reset valid", if_valid_o, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst inst_req_o", inst_req_o, 1'b0);
        chk("arst inst_addr_o", inst_addr_o, 32'h0);
        chk("arst pc_read_ready_o", pc_read_ready_o, 1'b0);
        chk("arst if_valid_o", if_valid_o, 1'b0);
        chk("arst if_pc_o", if_pc_o, 32'h0);
        chk("arst if_inst_o", if_inst_o, 32'h0);
        data_wait = 1;
        tick(); stall_i = 1'b0;
        tick(); rst = 1'b1;
        look(); chk("post-reset no valid", if_valid_o, 1'b0);
        tick(); look(); chk("late data_ok ignored", if_valid_o, 1'b0);
        tick(); look();
        chk("late data_ok no req", inst_req_o, 1'b0);
        chk("reset ready count", rr_cnt, 9);
        chk("final sb empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
